// File: rtl/flag_accum_pkg.sv
// Shared types and fold helpers for the multi-byte zero/parity flag accumulator.
// Holds the FSM encoding and zeroparity mode codes used by flag_accum and zeroparity.
package flag_accum_pkg;

  typedef enum logic [1:0] {
    FA_IDLE  = 2'd0,
    FA_ACCUM = 2'd1,
    FA_DONE  = 2'd2
  } fa_state_e;

  localparam logic ZP_MODE_ZERO   = 1'b0;
  localparam logic ZP_MODE_PARITY = 1'b1;

  // Zero mode ANDs "byte is zero" terms; parity mode XORs byte parities.
  function automatic logic fold_acc(input logic mode, input logic acc, input logic q);
    logic res;
    if (mode == ZP_MODE_PARITY) begin
      res = acc ^ q;
    end else begin
      res = acc & q;
    end
    return res;
  endfunction

  function automatic logic acc_init(input logic mode);
    logic res;
    if (mode == ZP_MODE_PARITY) begin
      res = 1'b0;
    end else begin
      res = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/zeroparity.sv
// 8-bit zero/parity checker: q = (data == 0) in zero mode, q = odd parity of data in parity mode.
// Purely combinational; the accumulator folds q once per accepted byte.
module zeroparity
  import flag_accum_pkg::*;
(
  input  logic       mode,
  input  logic [7:0] data,
  output logic       q
);

  always_comb begin
    q = 1'b0;
    case (mode)
      ZP_MODE_ZERO:   q = (data == 8'h00);
      ZP_MODE_PARITY: q = ^data;
      default:        q = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_accum.sv
// Multi-byte zero/parity flag accumulator; streams a 1..2^LEN_W byte word through zeroparity.
// Build option FLAG_ACCUM_DUAL_EN adds an opposite-mode checker driving flag_alt.
module flag_accum
  import flag_accum_pkg::*;
#(
  parameter int LEN_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             flag,
  output logic             flag_valid,
  output logic             flag_alt
);

  fa_state_e        state_r;
  fa_state_e        state_next_s;
  logic             mode_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic             acc_r;
  logic             flag_r;
  logic             flag_valid_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             q_s;
  logic             beat_s;

  zeroparity u_zp (
    .mode (mode_r),
    .data (in_data),
    .q    (q_s)
  );

  assign beat_s = in_valid && (state_r == FA_ACCUM);

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FA_IDLE: begin
        if (start) begin
          state_next_s = FA_ACCUM;
        end else begin
          state_next_s = FA_IDLE;
        end
      end
      FA_ACCUM: begin
        if (beat_s && (cnt_r == len_r)) begin
          state_next_s = FA_DONE;
        end else begin
          state_next_s = FA_ACCUM;
        end
      end
      FA_DONE: state_next_s = FA_IDLE;
      default: state_next_s = FA_IDLE;
    endcase
  end

  // in_ready/busy are registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FA_IDLE;
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      flag_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      in_ready_r   <= (state_next_s == FA_ACCUM);
      busy_r       <= (state_next_s != FA_IDLE);
      flag_valid_r <= (state_r == FA_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= ZP_MODE_ZERO;
      len_r  <= '0;
      cnt_r  <= '0;
      acc_r  <= 1'b0;
      flag_r <= 1'b0;
    end else begin
      case (state_r)
        FA_IDLE: begin
          if (start) begin
            mode_r <= mode;
            len_r  <= len;
            cnt_r  <= '0;
            acc_r  <= acc_init(mode);
          end
        end
        FA_ACCUM: begin
          if (beat_s) begin
            acc_r <= fold_acc(mode_r, acc_r, q_s);
            cnt_r <= cnt_r + LEN_W'(1);
          end
        end
        FA_DONE: flag_r <= acc_r;
        default: ;
      endcase
    end
  end

`ifdef FLAG_ACCUM_DUAL_EN
  logic q_alt_s;
  logic alt_acc_r;
  logic flag_alt_r;

  zeroparity u_zp_alt (
    .mode (~mode_r),
    .data (in_data),
    .q    (q_alt_s)
  );

  // Opposite-mode fold runs in lockstep with the main accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      alt_acc_r  <= 1'b0;
      flag_alt_r <= 1'b0;
    end else begin
      case (state_r)
        FA_IDLE: begin
          if (start) begin
            alt_acc_r <= acc_init(~mode);
          end
        end
        FA_ACCUM: begin
          if (beat_s) begin
            alt_acc_r <= fold_acc(~mode_r, alt_acc_r, q_alt_s);
          end
        end
        FA_DONE: flag_alt_r <= alt_acc_r;
        default: ;
      endcase
    end
  end

  assign flag_alt = flag_alt_r;
`else
  assign flag_alt = 1'b0;
`endif

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign flag       = flag_r;
  assign flag_valid = flag_valid_r;

endmodule

// File: tb/tb_flag_accum.sv
// Directed self-checking bench for flag_accum; expectations are hand-computed per vector.
// Honours FLAG_ACCUM_DUAL_EN to choose expected flag_alt values.
module tb_flag_accum;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [1:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       flag;
  logic       flag_valid;
  logic       flag_alt;

  int n_checks;
  int n_errors;

`ifdef FLAG_ACCUM_DUAL_EN
  localparam logic DUAL = 1'b1;
`else
  localparam logic DUAL = 1'b0;
`endif

  flag_accum #(.LEN_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .len        (len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .flag       (flag),
    .flag_valid (flag_valid),
    .flag_alt   (flag_alt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic m, input logic [1:0] l);
    start = 1'b1;
    mode  = m;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Offers a byte after 'gap' idle cycles; returns once the accepting edge has passed.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'hxx;
    if (!done) check_eq("accept_timeout", 8'd0, 8'd1);
  endtask

  // Called in the DONE cycle; flag_valid must pulse exactly one cycle later.
  task automatic finish_op(input string tag, input logic exp_flag, input logic exp_alt);
    check_eq({tag, "_done_fv"}, {7'd0, flag_valid}, 8'd0);
    check_eq({tag, "_done_rdy"}, {7'd0, in_ready}, 8'd0);
    check_eq({tag, "_done_busy"}, {7'd0, busy}, 8'd1);
    tick();
    check_eq({tag, "_fv"}, {7'd0, flag_valid}, 8'd1);
    check_eq({tag, "_flag"}, {7'd0, flag}, {7'd0, exp_flag});
    check_eq({tag, "_alt"}, {7'd0, flag_alt}, {7'd0, exp_alt & DUAL});
    tick();
    check_eq({tag, "_fv_drop"}, {7'd0, flag_valid}, 8'd0);
    check_eq({tag, "_flag_hold"}, {7'd0, flag}, {7'd0, exp_flag});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; len = 2'd0;
    in_valid = 1'b0; in_data = 8'h00;
    tick();
    tick();
    check_eq("rst_flag", {7'd0, flag}, 8'd0);
    check_eq("rst_fv", {7'd0, flag_valid}, 8'd0);
    check_eq("rst_rdy", {7'd0, in_ready}, 8'd0);
    check_eq("rst_busy", {7'd0, busy}, 8'd0);
    check_eq("rst_alt", {7'd0, flag_alt}, 8'd0);
    rst = 1'b0;
    tick();

    // Zero mode, four bytes.
    start_op(1'b0, 2'd3);
    check_eq("z4_rdy", {7'd0, in_ready}, 8'd1);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    finish_op("z4a", 1'b1, 1'b0);

    // Reset mid-ACCUM clears flag and returns to IDLE.
    start_op(1'b0, 2'd3);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    rst = 1'b1;
    tick();
    tick();
    check_eq("rsta_rdy", {7'd0, in_ready}, 8'd0);
    check_eq("rsta_busy", {7'd0, busy}, 8'd0);
    check_eq("rsta_flag", {7'd0, flag}, 8'd0);
    check_eq("rsta_fv", {7'd0, flag_valid}, 8'd0);
    rst = 1'b0;
    tick();

    start_op(1'b0, 2'd3);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    finish_op("z4b", 1'b0, 1'b1);

    // Parity, two bytes.
    start_op(1'b1, 2'd1);
    send_byte(8'h07, 0); send_byte(8'h01, 0);
    finish_op("p2a", 1'b0, 1'b0);
    start_op(1'b1, 2'd1);
    send_byte(8'h07, 0); send_byte(8'h03, 0);
    finish_op("p2b", 1'b1, 1'b0);

    // Stall with a start pulse (different mode/len) that must be ignored.
    start_op(1'b1, 2'd1);
    send_byte(8'h07, 0);
    start = 1'b1; mode = 1'b0; len = 2'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("stall_rdy", {7'd0, in_ready}, 8'd1);
    check_eq("stall_fv", {7'd0, flag_valid}, 8'd0);
    send_byte(8'h03, 0);
    finish_op("stall", 1'b1, 1'b0);

    // Single byte, then start held across DONE into IDLE.
    start_op(1'b1, 2'd0);
    send_byte(8'h80, 0);
    start = 1'b1; mode = 1'b0; len = 2'd0;
    check_eq("b2b_done_busy", {7'd0, busy}, 8'd1);
    check_eq("b2b_done_fv", {7'd0, flag_valid}, 8'd0);
    tick();
    check_eq("b2b_idle_busy", {7'd0, busy}, 8'd0);
    check_eq("b2b_fv", {7'd0, flag_valid}, 8'd1);
    check_eq("b2b_flag", {7'd0, flag}, 8'd1);
    tick();
    start = 1'b0;
    check_eq("b2b_acc_rdy", {7'd0, in_ready}, 8'd1);
    check_eq("b2b_acc_fv", {7'd0, flag_valid}, 8'd0);
    send_byte(8'h00, 0);
    finish_op("b2b2", 1'b1, 1'b0);

    // Reset in the DONE cycle drops the pending flag_valid.
    start_op(1'b1, 2'd0);
    send_byte(8'h80, 0);
    rst = 1'b1;
    tick();
    check_eq("rstd_fv", {7'd0, flag_valid}, 8'd0);
    check_eq("rstd_flag", {7'd0, flag}, 8'd0);
    rst = 1'b0;
    tick();

    // Dual-result vector: zero flag 0, parity of 0x0100 odd.
    start_op(1'b0, 2'd1);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    finish_op("dual", 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
